// File: rtl/ooo_sb_pkg.sv
// Shared types and helpers for the committed-store buffer: the entry record and
// the word-address extraction used by both the coalesce check and load forwarding.
package ooo_sb_pkg;

    localparam int SB_ADDR_W = 64;
    localparam int SB_DATA_W = 64;
    localparam int WORD_LSB  = $clog2(SB_DATA_W / 8);

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    function automatic logic [SB_ADDR_W-1:0] word_addr(input logic [SB_ADDR_W-1:0] addr,
                                                       input int unsigned          lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/sb_forward_match.sv
// Combinational youngest-match selector: scans the circular entry array from the
// oldest slot to the slot just behind the tail, so the youngest match wins.
module sb_forward_match #(
    parameter int DEPTH = 8,
    parameter int WA_W  = 64
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [WA_W-1:0]          waddr_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] tail_i,
    input  logic [WA_W-1:0]          ld_waddr_i,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);
    localparam int PTR_W = $clog2(DEPTH);

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_o = 1'b0;
        idx_o = '0;
        idx   = '0;
        // k = DEPTH is the oldest possible slot (tail itself when full); later hits override.
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (valid_i[idx] && (waddr_i[idx] == ld_waddr_i)) begin
                hit_o = 1'b1;
                idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/ooo_store_buffer.sv
// Committed-store FIFO between commit and dmem with youngest-entry load forwarding.
// Optional build macro STORE_COALESCE_EN merges a store into the youngest entry of the same word.
module ooo_store_buffer
    import ooo_sb_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [ADDR_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]          st_data_i,
    input  logic [ADDR_W-1:0]          ld_addr_i,
    output logic                       ld_hit_o,
    output logic [DATA_W-1:0]          ld_data_o,
    output logic                       dmem_writeEn_o,
    input  logic                       dmem_wr_ready_i,
    output logic [ADDR_W-1:0]          dmem_addressStore_o,
    output logic [DATA_W-1:0]          dmem_WriteData_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LSB   = $clog2(DATA_W / 8);

    sb_entry_t            entries [DEPTH];
    logic [PTR_W-1:0]     head, tail, fwd_idx;
    logic [CNT_W-1:0]     count;
    logic                 push, pop, coal, alloc, fwd_hit;
    logic [DEPTH-1:0]     ent_valid;
    logic [SB_ADDR_W-1:0] ent_waddr [DEPTH];
    logic [SB_ADDR_W-1:0] st_addr_x, ld_waddr;
    logic [SB_DATA_W-1:0] st_data_x;

    assign st_addr_x = SB_ADDR_W'(st_addr_i);
    assign st_data_x = SB_DATA_W'(st_data_i);
    assign ld_waddr  = word_addr(SB_ADDR_W'(ld_addr_i), LSB);

    // Ready depends only on registered count, never on dmem_wr_ready_i.
    assign st_ready_o     = (count != CNT_W'(DEPTH));
    assign dmem_writeEn_o = (count != '0);
    assign push           = st_valid_i && st_ready_o;
    assign pop            = dmem_writeEn_o && dmem_wr_ready_i;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);
    // A head entry leaving this cycle cannot absorb the store; it gets a fresh slot.
    assign coal = push && (count != '0)
               && (word_addr(entries[youngest].addr, LSB) == word_addr(st_addr_x, LSB))
               && !(pop && (youngest == head));
`else
    assign coal = 1'b0;
`endif
    assign alloc = push && !coal;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_waddr[i] = word_addr(entries[i].addr, LSB);
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH),
        .WA_W  (SB_ADDR_W)
    ) u_fwd (
        .valid_i    (ent_valid),
        .waddr_i    (ent_waddr),
        .tail_i     (tail),
        .ld_waddr_i (ld_waddr),
        .hit_o      (fwd_hit),
        .idx_o      (fwd_idx)
    );

    assign ld_hit_o            = fwd_hit;
    assign ld_data_o           = fwd_hit ? entries[fwd_idx].data[DATA_W-1:0] : '0;
    assign dmem_addressStore_o = dmem_writeEn_o ? entries[head].addr[ADDR_W-1:0] : '0;
    assign dmem_WriteData_o    = dmem_writeEn_o ? entries[head].data[DATA_W-1:0] : '0;
    assign count_o             = count;
    assign empty_o             = (count == '0);

    // Only control state is reset; entry payload is qualified by its valid bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (alloc) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr_x, data: st_data_x};
                tail          <= tail + PTR_W'(1);
            end
`ifdef STORE_COALESCE_EN
            if (coal) entries[youngest].data <= st_data_x;
`endif
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ooo_store_buffer.sv
// Directed self-checking bench for ooo_store_buffer (DEPTH=8, 64-bit address/data).
module tb_ooo_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [63:0] ld_addr = '0;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        wr_en;
    logic        rdy = 1'b0;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  count;
    logic        empty;

    int n_cmp  = 0;
    int n_fail = 0;

    ooo_store_buffer #(.DEPTH(8), .ADDR_W(64), .DATA_W(64)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .st_valid_i          (st_valid),
        .st_ready_o          (st_ready),
        .st_addr_i           (st_addr),
        .st_data_i           (st_data),
        .ld_addr_i           (ld_addr),
        .ld_hit_o            (ld_hit),
        .ld_data_o           (ld_data),
        .dmem_writeEn_o      (wr_en),
        .dmem_wr_ready_i     (rdy),
        .dmem_addressStore_o (wr_addr),
        .dmem_WriteData_o    (wr_data),
        .count_o             (count),
        .empty_o             (empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        st_valid = 1'b0;
        rdy      = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic push_st(input logic [63:0] a, input logic [63:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0)    begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        n_cmp++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        n_cmp++; if (wr_addr !== 64'h0) begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        n_cmp++; if (ld_hit !== 1'b0)   begin n_fail++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
        n_cmp++; if (ld_data !== 64'h0) begin n_fail++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_basic;
        logic [63:0] ea [3];
        ea = '{64'h10, 64'h18, 64'h20};
        rdy = 1'b0;
        push_st(64'h10, 64'hA0);
        n_cmp++; if (wr_en !== 1'b1)     begin n_fail++; $display("FAIL basic_latency got=%b exp=1", wr_en); end
        push_st(64'h18, 64'hA1);
        push_st(64'h20, 64'hA2);
        n_cmp++; if (count !== 4'd3)      begin n_fail++; $display("FAIL basic_count got=%0d exp=3", count); end
        n_cmp++; if (wr_addr !== 64'h10)  begin n_fail++; $display("FAIL basic_head_addr got=%h exp=10", wr_addr); end
        n_cmp++; if (wr_data !== 64'hA0)  begin n_fail++; $display("FAIL basic_head_data got=%h exp=a0", wr_data); end
        n_cmp++; if (empty !== 1'b0)      begin n_fail++; $display("FAIL basic_empty got=%b exp=0", empty); end
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b1;
            #1;
            n_cmp++; if (wr_addr !== ea[i]) begin n_fail++; $display("FAIL basic_drain%0d got=%h exp=%h", i, wr_addr, ea[i]); end
            tick();
        end
        rdy = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_drained empty=%b wr_en=%b exp=1/0", empty, wr_en); end
    endtask

    task automatic test_full;
        logic [63:0] exp_a;
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_st(64'h100 + 64'(8 * i), 64'hB00 + 64'(i));
        n_cmp++; if (count !== 4'd8)    begin n_fail++; $display("FAIL full_count got=%0d exp=8", count); end
        n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", st_ready); end
        st_valid = 1'b1;
        st_addr  = 64'h200;
        st_data  = 64'hC00;
        rdy      = 1'b1;
        #1;
        n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_popping got=%b exp=0", st_ready); end
        tick();
        rdy = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd7)    begin n_fail++; $display("FAIL full_after_pop got=%0d exp=7", count); end
        n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got=%b exp=1", st_ready); end
        tick();
        st_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd8)    begin n_fail++; $display("FAIL full_late_enq got=%0d exp=8", count); end
        rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_a = (i < 8) ? 64'h100 + 64'(8 * i) : 64'h200;
            #1;
            n_cmp++; if (wr_addr !== exp_a) begin n_fail++; $display("FAIL full_drain%0d got=%h exp=%h", i, wr_addr, exp_a); end
            tick();
        end
        rdy = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forward;
        logic [63:0] ea [3];
        logic [63:0] ed [3];
        int          n;
`ifdef STORE_COALESCE_EN
        ea = '{64'h40, 64'h80, 64'h0};
        ed = '{64'h2222, 64'h3333, 64'h0};
        n  = 2;
`else
        ea = '{64'h40, 64'h40, 64'h80};
        ed = '{64'h1111, 64'h2222, 64'h3333};
        n  = 3;
`endif
        do_reset();
        push_st(64'h40, 64'h1111);
        push_st(64'h40, 64'h2222);
        n_cmp++; if (count !== 4'(n - 1)) begin n_fail++; $display("FAIL fwd_count got=%0d exp=%0d", count, n - 1); end
        ld_addr = 64'h44;
        #1;
        n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 64'h2222) begin n_fail++; $display("FAIL fwd_young hit=%b data=%h exp=1/2222", ld_hit, ld_data); end
        ld_addr = 64'h48;
        #1;
        n_cmp++; if (ld_hit !== 1'b0 || ld_data !== 64'h0) begin n_fail++; $display("FAIL fwd_miss hit=%b data=%h exp=0/0", ld_hit, ld_data); end
        ld_addr  = 64'h80;
        st_valid = 1'b1;
        st_addr  = 64'h80;
        st_data  = 64'h3333;
        #1;
        n_cmp++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle hit=%b exp=0", ld_hit); end
        tick();
        st_valid = 1'b0;
        #1;
        n_cmp++; if (ld_hit !== 1'b1 || ld_data !== 64'h3333) begin n_fail++; $display("FAIL fwd_next_cycle hit=%b data=%h exp=1/3333", ld_hit, ld_data); end
        rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            n_cmp++; if (wr_addr !== ea[i] || wr_data !== ed[i]) begin n_fail++; $display("FAIL fwd_drain%0d got=%h/%h exp=%h/%h", i, wr_addr, wr_data, ea[i], ed[i]); end
            n_cmp++; if (ld_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_pop_visible%0d hit=%b exp=1", i, ld_hit); end
            tick();
        end
        rdy = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_end empty=%b hit=%b exp=1/0", empty, ld_hit); end
    endtask

    task automatic test_head_pop_store;
        do_reset();
        push_st(64'h50, 64'h1);
        rdy      = 1'b1;
        st_valid = 1'b1;
        st_addr  = 64'h50;
        st_data  = 64'h2;
        tick();
        st_valid = 1'b0;
        rdy      = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL headpop_count got=%0d exp=1", count); end
        n_cmp++; if (wr_addr !== 64'h50 || wr_data !== 64'h2) begin n_fail++; $display("FAIL headpop_entry got=%h/%h exp=50/2", wr_addr, wr_data); end
    endtask

    task automatic test_stream;
        int sent = 0;
        int got  = 0;
        do_reset();
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            st_valid = (sent < 20);
            st_addr  = 64'h1000 + 64'(8 * sent);
            st_data  = 64'hD000 + 64'(sent);
            rdy      = (cyc % 3) != 1;
            #1;
            if (wr_en && rdy) begin
                n_cmp++;
                if (wr_addr !== 64'h1000 + 64'(8 * got) || wr_data !== 64'hD000 + 64'(got)) begin
                    n_fail++;
                    $display("FAIL stream_order%0d got=%h/%h exp=%h/%h", got, wr_addr, wr_data, 64'h1000 + 64'(8 * got), 64'hD000 + 64'(got));
                end
                got++;
            end
            if (st_valid && st_ready) sent++;
            tick();
        end
        st_valid = 1'b0;
        rdy      = 1'b0;
        n_cmp++; if (got != 20) begin n_fail++; $display("FAIL stream_total got=%0d exp=20", got); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 6; i++) push_st(64'h300 + 64'(8 * i), 64'hE00 + 64'(i));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd5 || wr_addr !== 64'h308) begin n_fail++; $display("FAIL mid_setup count=%0d addr=%h exp=5/308", count, wr_addr); end
        rdy     = 1'b1;
        ld_addr = 64'h310;
        reset_n = 1'b0;
        #1;
        tick();
        n_cmp++; if (count !== 4'd0)    begin n_fail++; $display("FAIL mid_count got=%0d exp=0", count); end
        n_cmp++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL mid_wr_en got=%b exp=0", wr_en); end
        n_cmp++; if (ld_hit !== 1'b0)   begin n_fail++; $display("FAIL mid_ld_hit got=%b exp=0", ld_hit); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (empty !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_after empty=%b wr_en=%b exp=1/0", empty, wr_en); end
        rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_forward();
        test_head_pop_store();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
